alu_issue: RTL and testbench



---
 rtl/alu_issue.sv | 94 +++++++++
 tb/tb_alu_issue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: decodes an instruction, drives an external combinational ALU and returns its registered result.
// Define ALU_ISSUE_RSTATUS_EN to replace an overflowing result with a status code (1 ADD, 2 ADDI, 3 SUB).
module alu_issue #(
    parameter logic [4:0] RTYPE_OPCODE = 5'b00000,
    parameter logic [4:0] ADDI_OPCODE  = 5'b00101,
    parameter int         IMM_WIDTH    = 17
) (
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_data_rs,
    input  logic [31:0] in_data_rt,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shiftamt,
    input  logic [31:0] alu_result,
    input  logic        alu_isNotEqual,
    input  logic        alu_isLessThan,
    input  logic        alu_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_neq,
    output logic        out_lt,
    output logic        out_error
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nxt;
    logic        rtype, addi, legal, ovf, unused_bits;
    logic [4:0]  rop;
    logic [1:0]  dec_kind, ovf_kind;
    logic [31:0] dec_b;
    assign rtype       = in_instr[31:27] == RTYPE_OPCODE;
    assign addi        = in_instr[31:27] == ADDI_OPCODE;
    assign rop         = in_instr[6:2];
    assign legal       = addi || (rtype && rop <= 5'd5);
    assign dec_b       = addi ? {{(32-IMM_WIDTH){in_instr[IMM_WIDTH-1]}}, in_instr[IMM_WIDTH-1:0]} : in_data_rt;
    // ovf_kind doubles as the status code reported on overflow; 0 means overflow is not meaningful
    assign dec_kind    = addi ? 2'd2 : (rtype && rop == 5'd0) ? 2'd1 : (rtype && rop == 5'd1) ? 2'd3 : 2'd0;
    assign ovf         = (ovf_kind != 2'd0) && alu_overflow;
    assign unused_bits = ^in_instr;
    assign in_ready    = ctrl_reset_n && state == IDLE;
    assign out_valid   = state == RESP;
    always_ff @(posedge clock)
        state <= !ctrl_reset_n ? IDLE : state_nxt;
    always_comb begin
        state_nxt = state;
        if (state == IDLE && in_valid) state_nxt = legal ? EXEC : RESP;
        if (state == EXEC) state_nxt = RESP;
        if (state == RESP && out_ready) state_nxt = IDLE;
    end
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            alu_operandA <= '0;
            alu_operandB <= '0;
            alu_opcode   <= '0;
            alu_shiftamt <= '0;
            ovf_kind     <= '0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_neq      <= 1'b0;
            out_lt       <= 1'b0;
            out_error    <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            if (legal) begin
                alu_operandA <= in_data_rs;
                alu_operandB <= dec_b;
                alu_opcode   <= addi ? 5'd0 : rop;
                alu_shiftamt <= addi ? 5'd0 : in_instr[11:7];
                ovf_kind     <= dec_kind;
            end else begin
                out_result   <= '0;
                out_overflow <= 1'b0;
                out_neq      <= 1'b0;
                out_lt       <= 1'b0;
                out_error    <= 1'b1;
            end
        end else if (state == EXEC) begin
`ifdef ALU_ISSUE_RSTATUS_EN
            out_result   <= ovf ? {30'd0, ovf_kind} : alu_result;
`else
            out_result   <= alu_result;
`endif
            out_overflow <= ovf;
            out_neq      <= alu_isNotEqual;
            out_lt       <= alu_isLessThan;
            out_error    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed checks of alu_issue against a behavioural ALU and hand-computed results.
module tb_alu_issue;
    logic        clock = 1'b0, ctrl_reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, out_overflow, out_neq, out_lt, out_error;
    logic [31:0] in_instr = '0, in_data_rs = '0, in_data_rt = '0;
    logic [31:0] alu_operandA, alu_operandB, alu_result, out_result;
    logic [4:0]  alu_opcode, alu_shiftamt;
    logic        alu_isNotEqual, alu_isLessThan, alu_overflow;
    int          n_checks = 0, n_pass = 0;

    alu_issue dut (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_data_rs(in_data_rs), .in_data_rt(in_data_rt),
        .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
        .alu_opcode(alu_opcode), .alu_shiftamt(alu_shiftamt),
        .alu_result(alu_result), .alu_isNotEqual(alu_isNotEqual),
        .alu_isLessThan(alu_isLessThan), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_overflow(out_overflow), .out_neq(out_neq), .out_lt(out_lt), .out_error(out_error)
    );

    always #5 clock = ~clock;

    // Reference ALU; overflow is deliberately 1 for non-arithmetic ops so the DUT's gating is observable
    always_comb begin
        alu_result     = '0;
        alu_overflow   = 1'b1;
        alu_isNotEqual = alu_operandA != alu_operandB;
        alu_isLessThan = $signed(alu_operandA) < $signed(alu_operandB);
        case (alu_opcode)
            5'd0: begin
                alu_result   = alu_operandA + alu_operandB;
                alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
            end
            5'd1: begin
                alu_result   = alu_operandA - alu_operandB;
                alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
            end
            5'd2: alu_result = alu_operandA & alu_operandB;
            5'd3: alu_result = alu_operandA | alu_operandB;
            5'd4: alu_result = alu_operandA << alu_shiftamt;
            5'd5: alu_result = $unsigned($signed(alu_operandA) >>> alu_shiftamt);
            default: alu_result = '0;
        endcase
    end

    function automatic logic [31:0] rinstr(input logic [4:0] op, input logic [4:0] sh);
        return {5'b00000, 15'd0, sh, op, 2'b00};
    endfunction

    function automatic logic [31:0] iinstr(input logic [16:0] imm);
        return {5'b00101, 10'd0, imm};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
        in_valid = 1'b1; in_instr = instr; in_data_rs = rs; in_data_rt = rt;
        tick;
        in_valid = 1'b0;
    endtask

`ifdef ALU_ISSUE_RSTATUS_EN
    localparam logic [31:0] ADDI_OVF_RES = 32'd2;
    localparam logic [31:0] SUB_OVF_RES  = 32'd3;
`else
    localparam logic [31:0] ADDI_OVF_RES = 32'h8000_0000;
    localparam logic [31:0] SUB_OVF_RES  = 32'h7FFF_FFFF;
`endif

    initial begin
        tick; tick;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_alu_opA", alu_operandA, 0);
        ctrl_reset_n = 1'b1;
        #1;
        check("idle_in_ready", in_ready, 1);

        // R-type ADD 5+7
        out_ready = 1'b1;
        issue(rinstr(5'd0, 5'd0), 32'd5, 32'd7);
        check("add_exec_in_ready", in_ready, 0);
        check("add_exec_out_valid", out_valid, 0);
        check("add_alu_opB", alu_operandB, 32'd7);
        tick;
        check("add_out_valid", out_valid, 1);
        check("add_result", out_result, 32'd12);
        check("add_ovf", out_overflow, 0);
        check("add_neq", out_neq, 1);
        check("add_lt", out_lt, 1);
        check("add_err", out_error, 0);
        tick;
        check("add_drop_valid", out_valid, 0);
        check("add_alu_hold", alu_operandA, 32'd5);

        // ADDI overflow
        issue(iinstr(17'h00001), 32'h7FFF_FFFF, 32'd0);
        check("addi_ovf_opB", alu_operandB, 32'd1);
        tick;
        check("addi_ovf_result", out_result, ADDI_OVF_RES);
        check("addi_ovf_flag", out_overflow, 1);
        check("addi_ovf_err", out_error, 0);
        tick;

        // ADDI negative immediate
        issue(iinstr(17'h1FFFF), 32'd10, 32'd99);
        check("addi_neg_opB", alu_operandB, 32'hFFFF_FFFF);
        check("addi_neg_opcode", alu_opcode, 0);
        tick;
        check("addi_neg_result", out_result, 32'd9);
        check("addi_neg_ovf", out_overflow, 0);
        tick;

        // SLL by 31
        issue(rinstr(5'd4, 5'd31), 32'd1, 32'd0);
        check("sll_shamt", alu_shiftamt, 32'd31);
        tick;
        check("sll_result", out_result, 32'h8000_0000);
        check("sll_ovf_gated", out_overflow, 0);
        tick;

        // SUB with signed overflow
        issue(rinstr(5'd1, 5'd0), 32'h8000_0000, 32'd1);
        tick;
        check("sub_ovf_result", out_result, SUB_OVF_RES);
        check("sub_ovf_flag", out_overflow, 1);
        check("sub_lt", out_lt, 1);
        tick;

        // Illegal R-type op 6: response one cycle after accept
        issue(rinstr(5'd6, 5'd0), 32'd3, 32'd4);
        check("ill6_out_valid", out_valid, 1);
        check("ill6_err", out_error, 1);
        check("ill6_result", out_result, 0);
        check("ill6_neq", out_neq, 0);
        tick;

        // Illegal major opcode
        issue({5'b00111, 27'd0}, 32'd1, 32'd1);
        check("ill7_out_valid", out_valid, 1);
        check("ill7_err", out_error, 1);
        tick;

        // Backpressure then release together with a new request
        out_ready = 1'b0;
        issue(rinstr(5'd0, 5'd0), 32'd1, 32'd2);
        tick;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_result", out_result, 32'd3);
            check("bp_err", out_error, 0);
            tick;
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = rinstr(5'd2, 5'd0); in_data_rs = 32'hF0; in_data_rt = 32'h3C;
        tick;
        check("rel_valid_drop", out_valid, 0);
        check("rel_in_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
        check("rel_accept", in_ready, 0);
        check("rel_opcode", alu_opcode, 32'd2);
        tick;
        check("and_valid", out_valid, 1);
        check("and_result", out_result, 32'h30);
        tick;

        // Reset during EXEC discards the transaction
        issue(rinstr(5'd3, 5'd0), 32'd1, 32'd2);
        ctrl_reset_n = 1'b0;
        #1;
        check("rstx_in_ready", in_ready, 0);
        tick;
        ctrl_reset_n = 1'b1;
        check("rstx_opA", alu_operandA, 0);
        check("rstx_result", out_result, 0);
        for (int i = 0; i < 3; i++) begin
            check("rstx_no_valid", out_valid, 0);
            tick;
        end
        check("rstx_idle", in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
